// File: rtl/calendar_time_counter.sv
// calendar_time_counter
// Time-of-day and calendar counter advanced by a 1 Hz tick strobe.
// The hour is held internally in 24 h format. A validated load port can
// overwrite all fields. The display hour and the pm flag are derived
// combinationally from the registered hour.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_tick              1-cycle advance strobe
//   i_am_pm             display mode (1 = 12 h, 0 = 24 h)
//   i_set_en            1-cycle load strobe; takes priority over i_tick
//   i_set_*             load fields (hour is always 24 h)
//   o_set_err           1-cycle pulse when a load is rejected
//   o_sec .. o_year     current time/date (o_hour/o_pm in display format)
//   o_day_roll          1-cycle pulse when the day advances
//   o_year_wrap         1-cycle pulse when YEAR_MAX wraps to YEAR_MIN
module calendar_time_counter #(
   parameter int YEAR_W    = 14,
   parameter int YEAR_MIN  = 2000,
   parameter int YEAR_MAX  = 2399,
   parameter int LEAP_MODE = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_tick,
   input  logic              i_am_pm,
   input  logic              i_set_en,
   input  logic [5:0]        i_set_sec,
   input  logic [5:0]        i_set_min,
   input  logic [4:0]        i_set_hour,
   input  logic [4:0]        i_set_day,
   input  logic [3:0]        i_set_month,
   input  logic [YEAR_W-1:0] i_set_year,
   output logic              o_set_err,
   output logic [5:0]        o_sec,
   output logic [5:0]        o_min,
   output logic [4:0]        o_hour,
   output logic              o_pm,
   output logic [4:0]        o_day,
   output logic [3:0]        o_month,
   output logic [YEAR_W-1:0] o_year,
   output logic              o_day_roll,
   output logic              o_year_wrap
);

   localparam logic [YEAR_W-1:0] LP_YMIN = YEAR_W'(YEAR_MIN);
   localparam logic [YEAR_W-1:0] LP_YMAX = YEAR_W'(YEAR_MAX);
   localparam logic [YEAR_W-1:0] LP_Y100 = YEAR_W'(100);
   localparam logic [YEAR_W-1:0] LP_Y400 = YEAR_W'(400);
   localparam logic [YEAR_W-1:0] LP_YZERO = '0;

   // Leap-year decision; mode 0 is the plain divisible-by-4 rule.
   function automatic logic f_is_leap(input logic [YEAR_W-1:0] y);
      logic l4;
      logic l100;
      logic l400;
      l4   = (y[1:0] == 2'b00);
      l100 = ((y % LP_Y100) == LP_YZERO);
      l400 = ((y % LP_Y400) == LP_YZERO);
      if (LEAP_MODE == 0) begin
         return l4;
      end else begin
         return l4 & (~l100 | l400);
      end
   endfunction

   // Number of days in month m of year y (out-of-range months give 31).
   function automatic logic [4:0] f_dim(input logic [3:0] m, input logic [YEAR_W-1:0] y);
      case (m)
         4'd2:                      return f_is_leap(y) ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
         default:                   return 5'd31;
      endcase
   endfunction

   logic [5:0]        r_sec, r_min;
   logic [4:0]        r_hour, r_day;
   logic [3:0]        r_month;
   logic [YEAR_W-1:0] r_year;
   logic              r_set_err, r_day_roll, r_year_wrap;

   logic [5:0]        w_sec_nx, w_min_nx;
   logic [4:0]        w_hour_nx, w_day_nx;
   logic [3:0]        w_month_nx;
   logic [YEAR_W-1:0] w_year_nx;
   logic              w_set_err_nx, w_day_roll_nx, w_year_wrap_nx;

   logic [4:0]        w_dim_cur;
   logic [4:0]        w_dim_set;
   logic              w_set_ok;

   assign w_dim_cur = f_dim(r_month, r_year);
   assign w_dim_set = f_dim(i_set_month, i_set_year);

   assign w_set_ok = (i_set_sec <= 6'd59) && (i_set_min <= 6'd59) &&
                     (i_set_hour <= 5'd23) &&
                     (i_set_month >= 4'd1) && (i_set_month <= 4'd12) &&
                     (i_set_year >= LP_YMIN) && (i_set_year <= LP_YMAX) &&
                     (i_set_day >= 5'd1) && (i_set_day <= w_dim_set);

   // Next-state: load has priority over tick; tick ripples the full carry chain.
   always_comb begin
      w_sec_nx       = r_sec;
      w_min_nx       = r_min;
      w_hour_nx      = r_hour;
      w_day_nx       = r_day;
      w_month_nx     = r_month;
      w_year_nx      = r_year;
      w_set_err_nx   = 1'b0;
      w_day_roll_nx  = 1'b0;
      w_year_wrap_nx = 1'b0;
      if (i_set_en) begin
         if (w_set_ok) begin
            w_sec_nx   = i_set_sec;
            w_min_nx   = i_set_min;
            w_hour_nx  = i_set_hour;
            w_day_nx   = i_set_day;
            w_month_nx = i_set_month;
            w_year_nx  = i_set_year;
         end else begin
            w_set_err_nx = 1'b1;
         end
      end else if (i_tick) begin
         if (r_sec == 6'd59) begin
            w_sec_nx = 6'd0;
            if (r_min == 6'd59) begin
               w_min_nx = 6'd0;
               if (r_hour == 5'd23) begin
                  w_hour_nx     = 5'd0;
                  w_day_roll_nx = 1'b1;
                  // >= keeps a stale day from escaping the month range.
                  if (r_day >= w_dim_cur) begin
                     w_day_nx = 5'd1;
                     if (r_month >= 4'd12) begin
                        w_month_nx = 4'd1;
                        if (r_year >= LP_YMAX) begin
                           w_year_nx      = LP_YMIN;
                           w_year_wrap_nx = 1'b1;
                        end else begin
                           w_year_nx = r_year + YEAR_W'(1);
                        end
                     end else begin
                        w_month_nx = r_month + 4'd1;
                     end
                  end else begin
                     w_day_nx = r_day + 5'd1;
                  end
               end else begin
                  w_hour_nx = r_hour + 5'd1;
               end
            end else begin
               w_min_nx = r_min + 6'd1;
            end
         end else begin
            w_sec_nx = r_sec + 6'd1;
         end
      end else begin
         w_sec_nx = r_sec;
      end
   end

   // State register with synchronous reset to 2000-01-01 00:00:00.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sec       <= 6'd0;
         r_min       <= 6'd0;
         r_hour      <= 5'd0;
         r_day       <= 5'd1;
         r_month     <= 4'd1;
         r_year      <= LP_YMIN;
         r_set_err   <= 1'b0;
         r_day_roll  <= 1'b0;
         r_year_wrap <= 1'b0;
      end else begin
         r_sec       <= w_sec_nx;
         r_min       <= w_min_nx;
         r_hour      <= w_hour_nx;
         r_day       <= w_day_nx;
         r_month     <= w_month_nx;
         r_year      <= w_year_nx;
         r_set_err   <= w_set_err_nx;
         r_day_roll  <= w_day_roll_nx;
         r_year_wrap <= w_year_wrap_nx;
      end
   end

   // 12/24 h display conversion from the registered 24 h hour.
   always_comb begin
      if (i_am_pm) begin
         if (r_hour == 5'd0) begin
            o_hour = 5'd12;
         end else if (r_hour > 5'd12) begin
            o_hour = r_hour - 5'd12;
         end else begin
            o_hour = r_hour;
         end
         o_pm = (r_hour >= 5'd12);
      end else begin
         o_hour = r_hour;
         o_pm   = 1'b0;
      end
   end

   assign o_sec       = r_sec;
   assign o_min       = r_min;
   assign o_day       = r_day;
   assign o_month     = r_month;
   assign o_year      = r_year;
   assign o_set_err   = r_set_err;
   assign o_day_roll  = r_day_roll;
   assign o_year_wrap = r_year_wrap;

endmodule

// File: doc/calendar_time_counter.md
Name: calendar_time_counter

Overview:
Sequential time-of-day and calendar counter (sec/min/hour/day/month/year) advanced by a 1 Hz enable strobe. It supersedes the purely combinational day/hour limit decode. It adds a parametrised year range, a selectable leap rule (simple div-by-4 or full Gregorian), a validated load interface, 12/24 h display conversion and rollover pulses. It sits between the 1 Hz prescaler and the BCD/7-segment display path.

Parameters:
YEAR_W, 14, width of year output (binary, absolute year).
YEAR_MIN, 2000, reset year and wrap target.
YEAR_MAX, 2399, last valid year; YEAR_MIN <= YEAR_MAX < 2^YEAR_W.
LEAP_MODE, 1, 0 = leap iff year%4==0; 1 = Gregorian (year%4==0 and (year%100!=0 or year%400==0)).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
tick  in  1  1-cycle advance strobe (1 Hz).
am_pm  in  1  display mode: 1 = 12 h, 0 = 24 h.
set_en  in  1  1-cycle load strobe.
set_sec  in  6  load seconds.
set_min  in  6  load minutes.
set_hour  in  5  load hour, always 24 h format (0-23).
set_day  in  5  load day.
set_month  in  4  load month.
set_year  in  YEAR_W  load year.
set_err  out  1  1-cycle pulse: load rejected.
sec  out  6  seconds 0-59.
min  out  6  minutes 0-59.
hour  out  5  hour in display format (0-23, or 1-12).
pm  out  1  1 when internal hour >= 12; 0 in 24 h mode.
day  out  5  day 1..days_in_month.
month  out  4  month 1-12.
year  out  YEAR_W  year YEAR_MIN..YEAR_MAX.
day_roll  out  1  1-cycle pulse on day increment.
year_wrap  out  1  1-cycle pulse when YEAR_MAX wraps to YEAR_MIN.

Behaviour:
- Reset (rst=1 at clk edge): 00:00:00, day=1, month=1, year=YEAR_MIN; set_err, day_roll, year_wrap = 0. Reset overrides tick and set_en.
- All state is registered. Hour is kept internally in 24 h format. An event at edge n is visible at outputs after edge n.
- Tick cascade:
  - sec 59->0 carries to min.
  - min 59->0 carries to hour.
  - hour 23->0 carries to day.
  - day == days_in_month(month, year) -> 1 carries to month.
  - month 12->1 carries to year.
  - year YEAR_MAX -> YEAR_MIN.
  - The full cascade completes in one cycle.
- days_in_month: 2 -> 29 if leap else 28; 4, 6, 9, 11 -> 30; others -> 31. The leap rule follows LEAP_MODE and uses the current year.
- day_roll pulses in the same cycle the day/month/year registers update. year_wrap pulses only on the YEAR_MAX wrap. Both are 0 otherwise.
- Load: on set_en, all fields are checked:
  - sec, min <= 59; hour <= 23; 1 <= month <= 12;
  - YEAR_MIN <= year <= YEAR_MAX;
  - 1 <= day <= days_in_month(set_month, set_year).
  - If all are valid, the fields are written next edge and set_err=0.
  - If any is invalid, no register changes and set_err pulses 1 for one cycle.
- set_en and tick in the same cycle: load takes priority and the tick is dropped (no cascade, no pulses), whether or not the load is valid.
- Display: am_pm=0 -> hour = internal, pm = 0. am_pm=1 -> hour = 12 if internal is 0; internal-12 if internal > 12; else internal. pm = (internal >= 12).
- The display conversion is combinational from registered state. Toggling am_pm never alters internal time.
- tick with no set_en and rst low is the only way time advances. Multi-cycle tick high advances once per cycle.

Test Plan:
1. Reset, then 2000-02-28 23:59:59 loaded, one tick -> 2000-02-29 00:00:00, day_roll=1. Another load of 2100-02-28 23:59:59 (LEAP_MODE=1), tick -> 2100-03-01; with LEAP_MODE=0 -> 2100-02-29.
2. Load 2399-12-31 23:59:59, tick -> 2000-01-01 00:00:00, day_roll=1 and year_wrap=1 for exactly one cycle.
3. Load day=31 month=4, then day=29 month=2 year=2001, then hour=24 -> set_err=1 each time, all outputs unchanged from prior state.
4. set_en with valid 2024-06-15 10:20:30 and tick in the same cycle -> outputs exactly 10:20:30, no increment, no pulses.
5. am_pm=1 with internal hours 0, 11, 12, 13, 23 -> hour/pm = 12/0, 11/0, 12/1, 1/1, 11/1. Toggling am_pm mid-run leaves sec/min unchanged.
6. rst asserted mid-run with tick high -> next cycle 2000-01-01 00:00:00, no pulses. 86400 ticks from reset -> 2000-01-02 00:00:00, exactly one day_roll.
